// File: rtl/box_frame_scheduler_if.sv
// Handshake/bus bundle between the game registers, the frame scheduler
// and the per-pixel box comparators.
interface box_frame_scheduler_if #(
    parameter int NUM_OBJ = 2,
    parameter int HALF_W  = 6
);
    logic                      screenEnd;
    logic [31:0]               game_state;
    logic [NUM_OBJ*32-1:0]     obj_x;
    logic [NUM_OBJ*32-1:0]     obj_y;
    logic [NUM_OBJ-1:0]        obj_en;
    logic [NUM_OBJ*HALF_W-1:0] half_norm;
    logic [NUM_OBJ*HALF_W-1:0] half_small;
    logic [NUM_OBJ*10-1:0]     box_left;
    logic [NUM_OBJ*10-1:0]     box_right;
    logic [NUM_OBJ*9-1:0]      box_top;
    logic [NUM_OBJ*9-1:0]      box_bottom;
    logic [NUM_OBJ-1:0]        box_valid;
    logic                      update_done;
    logic                      busy;
    logic [15:0]               frame_count;

    modport master (
        output screenEnd, game_state, obj_x, obj_y,
        output obj_en, half_norm, half_small,
        input  box_left, box_right, box_top, box_bottom,
        input  box_valid, update_done, busy, frame_count
    );

    modport slave (
        input  screenEnd, game_state, obj_x, obj_y,
        input  obj_en, half_norm, half_small,
        output box_left, box_right, box_top, box_bottom,
        output box_valid, update_done, busy, frame_count
    );
endinterface

// File: rtl/box_frame_scheduler.sv
// Per-frame box edge scheduler: snapshot on screenEnd, compute one
// object per cycle into a shadow bank, then commit the bank atomically.
module box_frame_scheduler #(
    parameter int NUM_OBJ     = 2,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int SMALL_STATE = 3,
    parameter int HALF_W      = 6
) (
    input  logic                 clk_25mHz,
    input  logic                 reset,
    box_frame_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [10:0] X_MAX = 11'(SCREEN_W - 1);
    localparam logic [9:0]  Y_MAX = 10'(SCREEN_H - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OBJ - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [31:0]               r_gs;
    logic [NUM_OBJ*32-1:0]     r_x;
    logic [NUM_OBJ*32-1:0]     r_y;
    logic [NUM_OBJ-1:0]        r_en;
    logic [NUM_OBJ*HALF_W-1:0] r_hn;
    logic [NUM_OBJ*HALF_W-1:0] r_hs;
    logic [NUM_OBJ*10-1:0]     r_sh_l;
    logic [NUM_OBJ*10-1:0]     r_sh_r;
    logic [NUM_OBJ*9-1:0]      r_sh_t;
    logic [NUM_OBJ*9-1:0]      r_sh_b;
    logic [NUM_OBJ-1:0]        r_sh_v;
    logic [NUM_OBJ*10-1:0]     r_left;
    logic [NUM_OBJ*10-1:0]     r_right;
    logic [NUM_OBJ*9-1:0]      r_top;
    logic [NUM_OBJ*9-1:0]      r_bottom;
    logic [NUM_OBJ-1:0]        r_valid;
    logic                      r_done;
    logic                      r_busy;
    logic [15:0]               r_fc;

    logic [31:0]       w_cx;
    logic [31:0]       w_cy;
    logic [HALF_W-1:0] w_h;
    logic [10:0]       w_hx;
    logic [10:0]       w_cx11;
    logic [10:0]       w_xsub;
    logic [10:0]       w_xadd;
    logic [9:0]        w_hy;
    logic [9:0]        w_cy10;
    logic [9:0]        w_ysub;
    logic [9:0]        w_yadd;
    logic [9:0]        w_l;
    logic [9:0]        w_r;
    logic [8:0]        w_t;
    logic [8:0]        w_b;
    logic              w_v;

    // Edge math for the object selected by r_idx, from snapshot only
    always_comb begin
        w_cx = r_x[32*int'(r_idx) +: 32];
        w_cy = r_y[32*int'(r_idx) +: 32];
        w_h  = (r_gs == 32'(SMALL_STATE))
             ? r_hs[HALF_W*int'(r_idx) +: HALF_W]
             : r_hn[HALF_W*int'(r_idx) +: HALF_W];
        w_hx   = {{(11-HALF_W){1'b0}}, w_h};
        w_hy   = {{(10-HALF_W){1'b0}}, w_h};
        w_cx11 = {1'b0, w_cx[9:0]};
        w_cy10 = {1'b0, w_cy[8:0]};
        w_xsub = w_cx11 - w_hx;
        w_xadd = w_cx11 + w_hx;
        w_ysub = w_cy10 - w_hy;
        w_yadd = w_cy10 + w_hy;
        w_l = (w_cx11 < w_hx) ? 10'd0 : w_xsub[9:0];
        w_r = (w_xadd > X_MAX) ? X_MAX[9:0] : w_xadd[9:0];
        w_t = (w_cy10 < w_hy) ? 9'd0 : w_ysub[8:0];
        w_b = (w_yadd > 10'(Y_MAX)) ? Y_MAX[8:0] : w_yadd[8:0];
        w_v = r_en[r_idx] && (r_gs != 32'd0)
           && (w_cx < 32'(SCREEN_W)) && (w_cy < 32'(SCREEN_H));
    end

    always_ff @(posedge clk_25mHz) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_gs     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_en     <= '0;
            r_hn     <= '0;
            r_hs     <= '0;
            r_sh_l   <= '0;
            r_sh_r   <= '0;
            r_sh_t   <= '0;
            r_sh_b   <= '0;
            r_sh_v   <= '0;
            r_left   <= '0;
            r_right  <= '0;
            r_top    <= '0;
            r_bottom <= '0;
            r_valid  <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_fc     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.screenEnd) begin
                        r_gs    <= bus.game_state;
                        r_x     <= bus.obj_x;
                        r_y     <= bus.obj_y;
                        r_en    <= bus.obj_en;
                        r_hn    <= bus.half_norm;
                        r_hs    <= bus.half_small;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    r_sh_l[10*int'(r_idx) +: 10] <= w_l;
                    r_sh_r[10*int'(r_idx) +: 10] <= w_r;
                    r_sh_t[9*int'(r_idx) +: 9]   <= w_t;
                    r_sh_b[9*int'(r_idx) +: 9]   <= w_b;
                    r_sh_v[r_idx]                <= w_v;
                    if (r_idx == LAST) begin
                        r_state <= COMMIT;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                COMMIT: begin
                    r_left   <= r_sh_l;
                    r_right  <= r_sh_r;
                    r_top    <= r_sh_t;
                    r_bottom <= r_sh_b;
                    r_valid  <= r_sh_v;
                    r_done   <= 1'b1;
                    r_fc     <= r_fc + 16'd1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.box_left    = r_left;
    assign bus.box_right   = r_right;
    assign bus.box_top     = r_top;
    assign bus.box_bottom  = r_bottom;
    assign bus.box_valid   = r_valid;
    assign bus.update_done = r_done;
    assign bus.busy        = r_busy;
    assign bus.frame_count = r_fc;
endmodule

// File: tb/tb_box_frame_scheduler.sv
// Scoreboard bench for box_frame_scheduler: stimulus queues expected
// banks, a negedge monitor checks each commit against the queue.
module tb_box_frame_scheduler;
    localparam int N = 2;

    typedef struct packed {
        logic [19:0] l;
        logic [19:0] r;
        logic [17:0] t;
        logic [17:0] b;
        logic [1:0]  v;
        logic [1:0]  ce;
        logic [15:0] fc;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t m_e;

    box_frame_scheduler_if #(.NUM_OBJ(N), .HALF_W(6)) bus ();

    box_frame_scheduler dut (
        .clk_25mHz (clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    function automatic exp_t mk(int l0, int r0, int t0, int b0,
                                int l1, int r1, int t1, int b1,
                                logic [1:0] v, logic [1:0] ce, int fc);
        exp_t e;
        e.l   = {10'(l1), 10'(l0)};
        e.r   = {10'(r1), 10'(r0)};
        e.t   = {9'(t1), 9'(t0)};
        e.b   = {9'(b1), 9'(b0)};
        e.v   = v;
        e.ce  = ce;
        e.fc  = 16'(fc);
        e.cyc = '0;
        return e;
    endfunction

    // Commit monitor
    always @(negedge clk) begin
        if (bus.update_done === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_commit: got commit at %0d expected none",
                         cyc);
            end else begin
                m_e = q.pop_front();
                chk("commit_cycle", cyc, m_e.cyc);
                chk("frame_count", 32'(bus.frame_count), 32'(m_e.fc));
                chk("box_valid", 32'(bus.box_valid), 32'(m_e.v));
                for (int i = 0; i < N; i++) begin
                    if (m_e.ce[i]) begin
                        chk($sformatf("left%0d", i),
                            32'(bus.box_left[i*10 +: 10]),
                            32'(m_e.l[i*10 +: 10]));
                        chk($sformatf("right%0d", i),
                            32'(bus.box_right[i*10 +: 10]),
                            32'(m_e.r[i*10 +: 10]));
                        chk($sformatf("top%0d", i),
                            32'(bus.box_top[i*9 +: 9]),
                            32'(m_e.t[i*9 +: 9]));
                        chk($sformatf("bottom%0d", i),
                            32'(bus.box_bottom[i*9 +: 9]),
                            32'(m_e.b[i*9 +: 9]));
                    end
                end
            end
        end
    end

    task automatic set_obj(int i, logic [31:0] x, logic [31:0] y,
                           logic [5:0] hn, logic [5:0] hs);
        bus.obj_x[i*32 +: 32]    = x;
        bus.obj_y[i*32 +: 32]    = y;
        bus.half_norm[i*6 +: 6]  = hn;
        bus.half_small[i*6 +: 6] = hs;
    endtask

    // Returns at the negedge right after E0 (or after E0+hold-1)
    task automatic frame(exp_t e, int hold, bit expect_commit);
        @(negedge clk);
        bus.screenEnd = 1'b1;
        e.cyc = 32'(cyc + 1 + N + 1);
        if (expect_commit) q.push_back(e);
        repeat (hold) @(negedge clk);
        bus.screenEnd = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 12) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     q.size());
            q.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_left"}, 32'(bus.box_left), 0);
        chk({tag, "_right"}, 32'(bus.box_right), 0);
        chk({tag, "_top"}, 32'(bus.box_top), 0);
        chk({tag, "_bottom"}, 32'(bus.box_bottom), 0);
        chk({tag, "_valid"}, 32'(bus.box_valid), 0);
        chk({tag, "_done"}, 32'(bus.update_done), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_fc"}, 32'(bus.frame_count), 0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.screenEnd  = 1'b0;
        bus.game_state = '0;
        bus.obj_x      = '0;
        bus.obj_y      = '0;
        bus.obj_en     = '0;
        bus.half_norm  = '0;
        bus.half_small = '0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // basic sizing plus busy/update_done timing
        bus.game_state = 32'd1;
        set_obj(0, 320, 240, 20, 0);
        set_obj(1, 0, 0, 0, 0);
        bus.obj_en = 2'b01;
        frame(mk(300, 340, 220, 260, 0, 0, 0, 0, 2'b01, 2'b11, 1), 1, 1);
        chk("busy_e0", 32'(bus.busy), 1);
        chk("done_e0", 32'(bus.update_done), 0);
        @(negedge clk);
        chk("busy_e1", 32'(bus.busy), 1);
        @(negedge clk);
        chk("busy_e2", 32'(bus.busy), 1);
        @(negedge clk);
        chk("busy_e3", 32'(bus.busy), 0);
        chk("done_e3", 32'(bus.update_done), 1);
        @(negedge clk);
        chk("done_e4", 32'(bus.update_done), 0);
        drain();

        // small state selects half_small
        bus.game_state = 32'd3;
        set_obj(0, 320, 240, 20, 10);
        set_obj(1, 100, 100, 5, 20);
        bus.obj_en = 2'b11;
        frame(mk(310, 330, 230, 250, 80, 120, 80, 120,
                 2'b11, 2'b11, 2), 1, 1);
        drain();

        // clamping at all four borders
        bus.game_state = 32'd1;
        set_obj(0, 5, 475, 20, 0);
        set_obj(1, 630, 10, 20, 0);
        frame(mk(0, 25, 455, 479, 610, 639, 0, 30,
                 2'b11, 2'b11, 3), 1, 1);
        drain();

        // off-screen centres, including upper 32-bit bits
        set_obj(0, 700, 100, 20, 0);
        set_obj(1, 32'h0001_0140, 100, 20, 0);
        frame(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4), 1, 1);
        drain();

        // start screen: no valids, edges still update
        bus.game_state = 32'd0;
        set_obj(0, 320, 240, 20, 0);
        set_obj(1, 100, 100, 20, 0);
        frame(mk(300, 340, 220, 260, 80, 120, 80, 120,
                 2'b00, 2'b11, 5), 1, 1);
        drain();

        // overlapping screenEnd is dropped
        bus.game_state = 32'd1;
        set_obj(0, 200, 150, 10, 0);
        frame(mk(190, 210, 140, 160, 80, 120, 80, 120,
                 2'b11, 2'b11, 6), 2, 1);
        drain();
        chk("overlap_fc", 32'(bus.frame_count), 6);

        // inputs changed during COMPUTE are ignored
        set_obj(0, 320, 240, 20, 0);
        frame(mk(300, 340, 220, 260, 80, 120, 80, 120,
                 2'b11, 2'b11, 7), 1, 1);
        set_obj(0, 50, 60, 3, 0);
        bus.game_state = 32'd3;
        bus.obj_en = 2'b00;
        drain();

        // reset during COMPUTE discards the frame
        bus.game_state = 32'd1;
        bus.obj_en = 2'b11;
        set_obj(0, 320, 240, 20, 0);
        frame(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 1, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero("midrst");
        repeat (6) @(negedge clk);
        frame(mk(300, 340, 220, 260, 80, 120, 80, 120,
                 2'b11, 2'b11, 1), 1, 1);
        drain();

        // frame_count wrap
        @(negedge clk);
        force dut.r_fc = 16'hFFFF;
        @(negedge clk);
        release dut.r_fc;
        chk("preload_fc", 32'(bus.frame_count), 32'hFFFF);
        frame(mk(300, 340, 220, 260, 80, 120, 80, 120,
                 2'b11, 2'b11, 0), 1, 1);
        drain();

        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
